// File: rtl/imem_program_loader_if.sv
//----------------------------------------------------------------------------
// Module   : imem_program_loader_if
// Brief    : Byte-stream handshake and instruction-memory write bus.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface imem_program_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/imem_program_loader.sv
//----------------------------------------------------------------------------
// Module   : imem_program_loader
// Brief    : Framed byte-stream loader that fills instruction memory and
//            holds the pipeline in reset until the program is written.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module imem_program_loader #(
   parameter int ADDR_W = 8
) (
   input  wire logic               clk,
   input  wire logic               reset,
   imem_program_loader_if.master   bus,
   input  wire logic               start,
   output logic                    cpu_reset,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [15:0]             words_loaded
);

   localparam logic [16:0] c_depth = 17'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_HDR_HI = 3'd0,
      S_HDR_LO = 3'd1,
      S_DATA   = 3'd2,
      S_WRITE  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [15:0]       r_n;
   logic [15:0]       r_word_idx;
   logic [1:0]        r_byte_idx;
   logic [31:0]       r_shift;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_cpu_reset;
   logic              r_busy;
   logic              r_done;
   logic              r_overflow;
   logic [15:0]       r_words_loaded;

   logic              w_rx_ready;
   logic              w_accept;
   logic [15:0]       w_n_full;
   logic [15:0]       w_word_idx_inc;
   logic [31:0]       w_word;
   logic              w_in_range;

   assign w_rx_ready     = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_DATA);
   assign w_accept       = bus.rx_valid && w_rx_ready;
   assign w_n_full       = {r_n[15:8], bus.rx_data};
   assign w_word_idx_inc = r_word_idx + 16'd1;
   assign w_word         = {r_shift[23:0], bus.rx_data};
   // Words beyond the memory depth are dropped rather than aliased.
   assign w_in_range     = {1'b0, r_word_idx} < c_depth;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_HDR_HI;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_HDR_HI: begin
            if (w_accept) begin
               w_state_nxt = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (w_accept) begin
               w_state_nxt = (w_n_full == 16'd0) ? S_DONE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_accept && (r_byte_idx == 2'd3)) begin
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            w_state_nxt = (w_word_idx_inc == r_n) ? S_DONE : S_DATA;
         end
         S_DONE: begin
            if (start) begin
               w_state_nxt = S_HDR_HI;
            end
         end
         default: begin
            w_state_nxt = S_HDR_HI;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_n            <= 16'd0;
         r_word_idx     <= 16'd0;
         r_byte_idx     <= 2'd0;
         r_shift        <= 32'd0;
         r_imem_we      <= 1'b0;
         r_imem_addr    <= '0;
         r_imem_wdata   <= 32'd0;
         r_cpu_reset    <= 1'b1;
         r_busy         <= 1'b1;
         r_done         <= 1'b0;
         r_overflow     <= 1'b0;
         r_words_loaded <= 16'd0;
      end else begin
         r_imem_we   <= 1'b0;
         // Status follows the upcoming state so it changes on the DONE entry edge.
         r_done      <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_DONE);
         r_cpu_reset <= (w_state_nxt != S_DONE);
         case (r_state)
            S_HDR_HI: begin
               if (w_accept) begin
                  r_n[15:8] <= bus.rx_data;
               end
            end
            S_HDR_LO: begin
               if (w_accept) begin
                  r_n[7:0]   <= bus.rx_data;
                  r_byte_idx <= 2'd0;
                  r_word_idx <= 16'd0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_shift    <= w_word;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     if (w_in_range) begin
                        r_imem_we      <= 1'b1;
                        r_imem_addr    <= r_word_idx[ADDR_W-1:0];
                        r_imem_wdata   <= w_word;
                        r_words_loaded <= r_words_loaded + 16'd1;
                     end else begin
                        r_overflow <= 1'b1;
                     end
                  end
               end
            end
            S_WRITE: begin
               r_word_idx <= w_word_idx_inc;
               r_byte_idx <= 2'd0;
            end
            S_DONE: begin
               if (start) begin
                  r_overflow     <= 1'b0;
                  r_words_loaded <= 16'd0;
                  r_word_idx     <= 16'd0;
                  r_byte_idx     <= 2'd0;
               end
            end
            default: begin
               r_byte_idx <= 2'd0;
            end
         endcase
      end
   end

   assign bus.rx_ready   = w_rx_ready;
   assign bus.imem_we    = r_imem_we;
   assign bus.imem_addr  = r_imem_addr;
   assign bus.imem_wdata = r_imem_wdata;
   assign cpu_reset      = r_cpu_reset;
   assign busy           = r_busy;
   assign done           = r_done;
   assign overflow       = r_overflow;
   assign words_loaded   = r_words_loaded;

endmodule

`default_nettype wire

// File: tb/tb_imem_program_loader.sv
//----------------------------------------------------------------------------
// Module   : tb_imem_program_loader
// Brief    : Randomized scoreboard bench for imem_program_loader.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_imem_program_loader;

   localparam int ADDR_W = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [15:0] words_loaded;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   wr_t         exp_q[$];
   logic [31:0] words[$];

   imem_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_program_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .start        (start),
      .cpu_reset    (cpu_reset),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every write pulse must match the head of the queue in
   // address, data and the cycle right after the word's last byte.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.imem_we) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {31'd0, bus.imem_we}, 32'd0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("write_addr", 32'(bus.imem_addr), 32'(e.addr));
               chk("write_data", bus.imem_wdata, e.data);
               chk("write_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         chk("busy_vs_done", {31'd0, busy}, {31'd0, ~done});
         chk("cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, ~done});
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse, output int acc_cyc);
      bit got = 0;
      bit first = 1;
      int budget = 0;
      while (!got) begin
         @(negedge clk);
         start = first && pulse;
         first = 0;
         if (int'($urandom_range(99)) < gap) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
         end else begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = b;
            if (bus.rx_ready) got = 1;
         end
         budget++;
         if (budget > 500) begin
            $display("FAIL send_byte_timeout: got no ready expected ready within 500 cycles");
            n_fail++;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "stalled");
         end
      end
      acc_cyc = cyc + 1;
   endtask

   // Streams header + words[0..n-1]; the model expects address i for word i
   // only while i < DEPTH, and min(n, DEPTH) words with overflow iff n > DEPTH.
   task automatic run_load(input int n, input int gap, input int start_at);
      int          acc;
      int          idx = 0;
      logic [15:0] nn = 16'(n);
      logic [31:0] wv;
      wr_t         e;
      send_byte(nn[15:8], gap, start_at == idx, acc); idx++;
      send_byte(nn[7:0], gap, start_at == idx, acc); idx++;
      for (int w = 0; w < n; w++) begin
         wv = words[w];
         for (int k = 0; k < 4; k++) begin
            send_byte(wv[31-8*k -: 8], gap, start_at == idx, acc); idx++;
         end
         if (w < DEPTH) begin
            e.addr = w; e.data = wv; e.cyc = acc;
            exp_q.push_back(e);
         end
         @(negedge clk);
         start = 1'b0;
         chk("ready_low_in_write", {31'd0, bus.rx_ready}, 32'd0);
         bus.rx_valid = 1'b1;
         if (w == n - 1) begin
            chk("not_done_in_write", {31'd0, done}, 32'd0);
            bus.rx_data = 8'($urandom);
         end else begin
            wv = words[w+1];
            bus.rx_data = wv[31:24];
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_reached", {31'd0, done}, 32'd1);
      chk("ready_low_in_done", {31'd0, bus.rx_ready}, 32'd0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      chk("words_loaded", 32'(words_loaded), 32'((n < DEPTH) ? n : DEPTH));
      chk("overflow", {31'd0, overflow}, (n > DEPTH) ? 32'd1 : 32'd0);
      chk("cpu_reset_released", {31'd0, cpu_reset}, 32'd0);
      chk("pending_writes", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic rearm();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rearm_busy", {31'd0, busy}, 32'd1);
      chk("rearm_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("rearm_done", {31'd0, done}, 32'd0);
      chk("rearm_overflow", {31'd0, overflow}, 32'd0);
      chk("rearm_words_loaded", 32'(words_loaded), 32'd0);
      chk("rearm_ready", {31'd0, bus.rx_ready}, 32'd1);
   endtask

   task automatic check_reset_values();
      chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
      chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
      chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_words_loaded", 32'(words_loaded), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end expected end before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      wr_t e;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #3 reset = 1'b0;
      #14;
      check_reset_values();
      @(negedge clk);
      reset = 1'b1;
      #1 chk("ready_after_release", {31'd0, bus.rx_ready}, 32'd1);

      // Basic load
      words = '{32'h20080005, 32'h8C090004};
      run_load(2, 0, -1);

      // Empty program
      rearm();
      run_load(0, 0, -1);

      // Overflow: five words into a four-word memory
      rearm();
      words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
      run_load(5, 0, -1);

      // Backpressure with a start pulse during DATA (ignored)
      rearm();
      words = '{32'h20080005, 32'h8C090004};
      run_load(2, 50, 5);

      // Reset in the middle of word 1
      rearm();
      send_byte(8'h00, 0, 0, acc);
      send_byte(8'h03, 0, 0, acc);
      send_byte(8'hCA, 0, 0, acc);
      send_byte(8'hFE, 0, 0, acc);
      send_byte(8'hF0, 0, 0, acc);
      send_byte(8'h0D, 0, 0, acc);
      e.addr = 0; e.data = 32'hCAFEF00D; e.cyc = acc;
      exp_q.push_back(e);
      send_byte(8'h12, 0, 0, acc);
      send_byte(8'h34, 0, 0, acc);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      chk("pre_reset_words_loaded", 32'(words_loaded), 32'd1);
      #2 reset = 1'b0;
      #1 check_reset_values();
      chk("pre_reset_pending", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      words = '{32'hDEADBEEF};
      run_load(1, 0, -1);

      // Randomized loads, including overflow lengths
      for (int t = 0; t < 10; t++) begin
         int n;
         int gap;
         int sa;
         n = int'($urandom_range(0, 7));
         gap = int'($urandom_range(0, 60));
         sa = int'($urandom_range(0, 2 + 4 * n + 3));
         words.delete();
         for (int i = 0; i < n; i++) words.push_back($urandom);
         rearm();
         run_load(n, gap, sa);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
